fifo_window_reader: RTL and testbench

FIFO_WINDOW_READER -- requirements
Module: fifo_window_reader

---
 rtl/fifo_window_reader.sv | 174 +++++++++++++++++
 tb/tb_fifo_window_reader.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_window_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : fifo_window_reader                                         |
// | Description : Pulls 8-bit pixels from a line-buffer FIFO and emits a     |
// |               horizontal 3-tap window {oldest, middle, newest} with      |
// |               column/row coordinates and sof/eol markers over a          |
// |               valid/ready handshake. A 1-entry skid register absorbs     |
// |               the read that is already in flight when the output stalls. |
// | Options     : WIN_EDGE_REPLICATE_EN - emit a window at every column,     |
// |               replicating the first pixel of a row into missing taps.    |
// |               Undefined: only columns >= 2 produce windows.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module fifo_window_reader #(
  parameter int IMG_W = 97,
  parameter int IMG_H = 97
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        fifo_empty,
  output logic        fifo_rd,
  input  logic [7:0]  fifo_q,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [23:0] win,
  output logic [9:0]  col,
  output logic [9:0]  row,
  output logic        sof,
  output logic        eol
);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [9:0] c_last_col = 10'(IMG_W - 1);
  localparam logic [9:0] c_last_row = 10'(IMG_H - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic        r_rd_pend;
  logic [9:0]  r_col_nxt;     // column of the next pixel to be consumed
  logic [9:0]  r_row_nxt;     // row of the next pixel to be consumed
  logic [7:0]  r_hist0;       // previous pixel of the current row
  logic [7:0]  r_hist1;       // pixel before r_hist0
  logic        r_skid_full;
  logic [23:0] r_skid_win;
  logic [9:0]  r_skid_col;
  logic [9:0]  r_skid_row;
  logic        r_skid_sof;
  logic        r_skid_eol;

  logic        w_cap;
  logic        w_emit;
  logic        w_out_free;
  logic        w_row_start;
  logic        w_frame_end;
  logic [23:0] w_new_win;
  logic        w_new_sof;
  logic        w_new_eol;

  // No read into a full skid, nor while a stalled output already has a pixel in flight behind it.
  assign fifo_rd     = rst_n && !fifo_empty && !r_skid_full && !(out_valid && !out_ready && r_rd_pend);
  assign w_cap       = r_rd_pend;
  assign w_out_free  = !out_valid || out_ready;
  assign w_row_start = (r_col_nxt == 10'd0);
  assign w_frame_end = w_cap && w_new_eol && (r_row_nxt == c_last_row);

  // Form the window and markers for the pixel presented on fifo_q this cycle.
  always_comb begin
    w_new_win = w_row_start ? {fifo_q, fifo_q, fifo_q} : {r_hist1, r_hist0, fifo_q};
    w_new_eol = (r_col_nxt == c_last_col);
`ifdef WIN_EDGE_REPLICATE_EN
    w_new_sof = (r_row_nxt == 10'd0) && w_row_start;
    w_emit    = w_cap;
`else
    w_new_sof = (r_row_nxt == 10'd0) && (r_col_nxt == 10'd2);
    w_emit    = w_cap && (r_col_nxt >= 10'd2);
`endif
  end

  // Frame FSM: IDLE until the first pixel is consumed, back to IDLE after the last pixel of the frame.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_cap) w_state_nxt = S_RUN;
      S_RUN:   if (w_frame_end) w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Read tracking, coordinate counters and per-row history; history restarts at column 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_pend <= 1'b0;
      r_col_nxt <= 10'd0;
      r_row_nxt <= 10'd0;
      r_hist0   <= 8'd0;
      r_hist1   <= 8'd0;
    end else begin
      r_rd_pend <= fifo_rd;
      if (w_cap) begin
        if (w_new_eol) begin
          r_col_nxt <= 10'd0;
          r_row_nxt <= (r_row_nxt == c_last_row) ? 10'd0 : r_row_nxt + 10'd1;
        end else begin
          r_col_nxt <= r_col_nxt + 10'd1;
        end
        r_hist1 <= w_row_start ? fifo_q : r_hist0;
        r_hist0 <= fifo_q;
      end
    end
  end

  // Output register: skid contents take priority over a freshly captured pixel; held while stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      win       <= 24'd0;
      col       <= 10'd0;
      row       <= 10'd0;
      sof       <= 1'b0;
      eol       <= 1'b0;
    end else if (w_out_free) begin
      if (r_skid_full) begin
        out_valid <= 1'b1;
        win       <= r_skid_win;
        col       <= r_skid_col;
        row       <= r_skid_row;
        sof       <= r_skid_sof;
        eol       <= r_skid_eol;
      end else if (w_emit) begin
        out_valid <= 1'b1;
        win       <= w_new_win;
        col       <= r_col_nxt;
        row       <= r_row_nxt;
        sof       <= w_new_sof;
        eol       <= w_new_eol;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Skid register: catches a captured pixel when the output cannot take it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_skid_full <= 1'b0;
      r_skid_win  <= 24'd0;
      r_skid_col  <= 10'd0;
      r_skid_row  <= 10'd0;
      r_skid_sof  <= 1'b0;
      r_skid_eol  <= 1'b0;
    end else if ((w_out_free && r_skid_full) || (!w_out_free && w_emit)) begin
      r_skid_full <= w_emit;
      if (w_emit) begin
        r_skid_win <= w_new_win;
        r_skid_col <= r_col_nxt;
        r_skid_row <= r_row_nxt;
        r_skid_sof <= w_new_sof;
        r_skid_eol <= w_new_eol;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fifo_window_reader.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_fifo_window_reader                                      |
// | Description : Directed, table-driven bench for fifo_window_reader.       |
// |               Instance A uses the default 97x97 geometry, instance B a   |
// |               4x2 frame. Each has its own behavioural FIFO.              |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_fifo_window_reader;
`ifdef WIN_EDGE_REPLICATE_EN
  localparam int C_FIRST = 0;
`else
  localparam int C_FIRST = 2;
`endif

  typedef struct packed {
    logic [23:0] win;
    logic [9:0]  col;
    logic [9:0]  row;
    logic        sof;
    logic        eol;
  } out_t;

  typedef struct packed {
    logic [7:0] pix;
    logic       emit;
    out_t       exp;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // instance A signals and FIFO
  logic        a_rst_n, a_empty, a_rd, a_ready, a_valid, a_sof, a_eol;
  logic        a_gate = 1'b0;
  logic [7:0]  a_q = 8'h00;
  logic [23:0] a_win;
  logic [9:0]  a_col, a_row;
  logic [7:0]  a_mem [256];
  int          a_wr = 0, a_rp = 0, a_viol = 0, a_rd_total = 0;
  out_t        a_cap [$];
  int          a_cap_cyc [$];
  int          a_rd_cyc [$];

  // instance B signals and FIFO
  logic        b_rst_n, b_empty, b_rd, b_ready, b_valid, b_sof, b_eol;
  logic [7:0]  b_q = 8'h00;
  logic [23:0] b_win;
  logic [9:0]  b_col, b_row;
  logic [7:0]  b_mem [64];
  int          b_wr = 0, b_rp = 0, b_viol = 0;
  out_t        b_cap [$];

  logic [7:0]  px [32];
  vec_t        tbl [12];

  assign a_empty = (a_wr == a_rp) || a_gate;
  assign b_empty = (b_wr == b_rp);

  fifo_window_reader dut_a (
    .clk(clk), .rst_n(a_rst_n), .fifo_empty(a_empty), .fifo_rd(a_rd), .fifo_q(a_q),
    .out_ready(a_ready), .out_valid(a_valid), .win(a_win), .col(a_col), .row(a_row),
    .sof(a_sof), .eol(a_eol)
  );

  fifo_window_reader #(.IMG_W(4), .IMG_H(2)) dut_b (
    .clk(clk), .rst_n(b_rst_n), .fifo_empty(b_empty), .fifo_rd(b_rd), .fifo_q(b_q),
    .out_ready(b_ready), .out_valid(b_valid), .win(b_win), .col(b_col), .row(b_row),
    .sof(b_sof), .eol(b_eol)
  );

  // FIFO read side: data appears one cycle after the read strobe
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (a_rd) begin
      a_q  <= a_mem[a_rp];
      a_rp <= a_rp + 1;
    end
    if (b_rd) begin
      b_q  <= b_mem[b_rp];
      b_rp <= b_rp + 1;
    end
  end

  // Output monitor, sampled mid-cycle
  always @(negedge clk) begin
    if (a_valid && a_ready) begin
      a_cap.push_back({a_win, a_col, a_row, a_sof, a_eol});
      a_cap_cyc.push_back(cyc);
    end
    if (a_rd) begin
      a_rd_cyc.push_back(cyc);
      a_rd_total = a_rd_total + 1;
    end
    if (a_rd && a_empty) a_viol = a_viol + 1;
    if (b_valid && b_ready) b_cap.push_back({b_win, b_col, b_row, b_sof, b_eol});
    if (b_rd && b_empty) b_viol = b_viol + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish required finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_a(input logic [7:0] v);
    a_mem[a_wr] = v;
    a_wr = a_wr + 1;
  endtask

  task automatic push_b(input logic [7:0] v);
    b_mem[b_wr] = v;
    b_wr = b_wr + 1;
  endtask

  task automatic clear_a();
    a_cap.delete();
    a_cap_cyc.delete();
    a_rd_cyc.delete();
  endtask

  task automatic reset_a();
    a_rst_n = 1'b0;
    tick(2);
    clear_a();
    a_rst_n = 1'b1;
  endtask

  task automatic wait_a(input int n, input string name);
    int k = 0;
    while (a_cap.size() < n && k < 300) begin
      tick(1);
      k++;
    end
    check(name, 64'(a_cap.size()), 64'(n));
  endtask

  task automatic wait_b(input int n, input string name);
    int k = 0;
    while (b_cap.size() < n && k < 300) begin
      tick(1);
      k++;
    end
    check(name, 64'(b_cap.size()), 64'(n));
  endtask

  function automatic out_t mk(input logic [23:0] w, input int c, input int r, input logic s, input logic e);
    return {w, 10'(c), 10'(r), s, e};
  endfunction

  // Reference window of row 0 built from px[]
  function automatic logic [23:0] win_at(input int c);
    if (c == 0) return {px[0], px[0], px[0]};
    if (c == 1) return {px[0], px[0], px[1]};
    return {px[c-2], px[c-1], px[c]};
  endfunction

  task automatic compare_a(input int npix, input string name);
    for (int c = C_FIRST; c < npix; c++) begin
      if (c - C_FIRST < a_cap.size())
        check($sformatf("%s_c%0d", name, c), 64'(a_cap[c - C_FIRST]),
              64'(mk(win_at(c), c, 0, c == C_FIRST, 1'b0)));
    end
  endtask

  initial begin
    logic [46:0] held;
    int          bad;
    int          rd0;
    int          nxt;
    int          n8;
    int          nall;
    int          k;
    logic        found;

    // ---------------- T1: reset state, first window, latency ----------------
    a_rst_n = 1'b0; b_rst_n = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
`ifdef WIN_EDGE_REPLICATE_EN
    px[0] = 8'hAA; px[1] = 8'hBB; px[2] = 8'hCC;
`else
    px[0] = 8'h10; px[1] = 8'h20; px[2] = 8'h30;
`endif
    for (int i = 0; i < 3; i++) push_a(px[i]);
    tick(3);
    check("rst_valid",   64'(a_valid), 64'(0));
    check("rst_win",     64'(a_win),   64'(0));
    check("rst_col_row", 64'({a_col, a_row}), 64'(0));
    check("rst_sof_eol", 64'({a_sof, a_eol}), 64'(0));
    check("rst_fifo_rd", 64'(a_rd),    64'(0));
    a_rst_n = 1'b1; b_rst_n = 1'b1;
    wait_a(3 - C_FIRST, "t1_count");
    tick(6);
    check("t1_exact_count", 64'(a_cap.size()), 64'(3 - C_FIRST));
    compare_a(3, "t1_win");
    if (a_cap_cyc.size() >= 3 - C_FIRST && a_rd_cyc.size() >= 3)
      check("t1_latency", 64'(a_cap_cyc[2 - C_FIRST] - a_rd_cyc[2]), 64'(2));

    // ---------------- T2: 5-cycle stall during a stream ----------------
    reset_a();
    for (int i = 0; i < 20; i++) begin
      px[i] = 8'h40 + 8'(i);
      push_a(px[i]);
    end
    k = 0;
    while (a_cap.size() < 3 && k < 50) begin
      tick(1);
      k++;
    end
    a_ready = 1'b0;
    held = {a_valid, a_win, a_col, a_row, a_sof, a_eol};
    rd0 = a_rd_total;
    bad = 0;
    check("t2_stall_valid", 64'(a_valid), 64'(1));
    for (int i = 0; i < 5; i++) begin
      tick(1);
      if ({a_valid, a_win, a_col, a_row, a_sof, a_eol} !== held) bad++;
    end
    check("t2_held_cycles_bad", 64'(bad), 64'(0));
    check("t2_rd_after_stall", 64'(a_rd), 64'(0));
    check("t2_reads_in_stall_le1", 64'((a_rd_total - rd0) <= 1), 64'(1));
    a_ready = 1'b1;
    wait_a(20 - C_FIRST, "t2_count");
    tick(6);
    check("t2_exact_count", 64'(a_cap.size()), 64'(20 - C_FIRST));
    compare_a(20, "t2_win");

    // ---------------- T3: fifo_empty toggling every cycle ----------------
    reset_a();
    a_viol = 0;
    for (int i = 0; i < 12; i++) begin
      px[i] = 8'h80 + 8'(3 * i);
      push_a(px[i]);
    end
    for (int i = 0; i < 40; i++) begin
      a_gate = ~a_gate;
      tick(1);
    end
    a_gate = 1'b0;
    wait_a(12 - C_FIRST, "t3_count");
    compare_a(12, "t3_win");
    check("t3_rd_while_empty", 64'(a_viol), 64'(0));

    // ---------------- T4: asynchronous reset mid-row with a read in flight ----------------
    reset_a();
    for (int i = 0; i < 16; i++) push_a(8'hC0 + 8'(i));
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      tick(1);
      if (a_valid && a_col == 10'd5 && dut_a.r_rd_pend) found = 1'b1;
    end
    check("t4_col5_inflight", 64'(found), 64'(1));
    a_rst_n = 1'b0;
    #1;
    check("t4_async_valid",   64'(a_valid), 64'(0));
    check("t4_async_win",     64'(a_win),   64'(0));
    check("t4_async_col_row", 64'({a_col, a_row}), 64'(0));
    check("t4_async_sof_eol", 64'({a_sof, a_eol}), 64'(0));
    check("t4_async_fifo_rd", 64'(a_rd), 64'(0));
    tick(2);
    nxt = a_rp;
    clear_a();
    a_rst_n = 1'b1;
    wait_a(1, "t4_count");
    if (a_cap.size() >= 1)
`ifdef WIN_EDGE_REPLICATE_EN
      check("t4_first_after_rst", 64'(a_cap[0]),
            64'(mk({a_mem[nxt], a_mem[nxt], a_mem[nxt]}, 0, 0, 1'b1, 1'b0)));
`else
      check("t4_first_after_rst", 64'(a_cap[0]),
            64'(mk({a_mem[nxt], a_mem[nxt+1], a_mem[nxt+2]}, 2, 0, 1'b1, 1'b0)));
`endif

    // ---------------- T5: 4x2 frame, table driven ----------------
`ifdef WIN_EDGE_REPLICATE_EN
    tbl[0]  = {8'h01, 1'b1, mk(24'h010101, 0, 0, 1'b1, 1'b0)};
    tbl[1]  = {8'h02, 1'b1, mk(24'h010102, 1, 0, 1'b0, 1'b0)};
    tbl[2]  = {8'h03, 1'b1, mk(24'h010203, 2, 0, 1'b0, 1'b0)};
    tbl[3]  = {8'h04, 1'b1, mk(24'h020304, 3, 0, 1'b0, 1'b1)};
    tbl[4]  = {8'h05, 1'b1, mk(24'h050505, 0, 1, 1'b0, 1'b0)};
    tbl[5]  = {8'h06, 1'b1, mk(24'h050506, 1, 1, 1'b0, 1'b0)};
    tbl[6]  = {8'h07, 1'b1, mk(24'h050607, 2, 1, 1'b0, 1'b0)};
    tbl[7]  = {8'h08, 1'b1, mk(24'h060708, 3, 1, 1'b0, 1'b1)};
    tbl[8]  = {8'h09, 1'b1, mk(24'h090909, 0, 0, 1'b1, 1'b0)};
    tbl[9]  = {8'h0A, 1'b1, mk(24'h09090A, 1, 0, 1'b0, 1'b0)};
    tbl[10] = {8'h0B, 1'b1, mk(24'h090A0B, 2, 0, 1'b0, 1'b0)};
    tbl[11] = {8'h0C, 1'b1, mk(24'h0A0B0C, 3, 0, 1'b0, 1'b1)};
`else
    tbl[0]  = {8'h01, 1'b0, mk(24'h000000, 0, 0, 1'b0, 1'b0)};
    tbl[1]  = {8'h02, 1'b0, mk(24'h000000, 1, 0, 1'b0, 1'b0)};
    tbl[2]  = {8'h03, 1'b1, mk(24'h010203, 2, 0, 1'b1, 1'b0)};
    tbl[3]  = {8'h04, 1'b1, mk(24'h020304, 3, 0, 1'b0, 1'b1)};
    tbl[4]  = {8'h05, 1'b0, mk(24'h000000, 0, 1, 1'b0, 1'b0)};
    tbl[5]  = {8'h06, 1'b0, mk(24'h000000, 1, 1, 1'b0, 1'b0)};
    tbl[6]  = {8'h07, 1'b1, mk(24'h050607, 2, 1, 1'b0, 1'b0)};
    tbl[7]  = {8'h08, 1'b1, mk(24'h060708, 3, 1, 1'b0, 1'b1)};
    tbl[8]  = {8'h09, 1'b0, mk(24'h000000, 0, 0, 1'b0, 1'b0)};
    tbl[9]  = {8'h0A, 1'b0, mk(24'h000000, 1, 0, 1'b0, 1'b0)};
    tbl[10] = {8'h0B, 1'b1, mk(24'h090A0B, 2, 0, 1'b1, 1'b0)};
    tbl[11] = {8'h0C, 1'b1, mk(24'h0A0B0C, 3, 0, 1'b0, 1'b1)};
`endif
    n8 = 0;
    nall = 0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].emit) begin
        nall++;
        if (i < 8) n8++;
      end
    end
    for (int i = 0; i < 8; i++) push_b(tbl[i].pix);
    wait_b(n8, "t5_frame_count");
    tick(4);
    check("t5_frame_exact", 64'(b_cap.size()), 64'(n8));
    check("t5_fsm_idle", 64'(dut_b.r_state), 64'(0));
    for (int i = 8; i < 12; i++) push_b(tbl[i].pix);
    wait_b(nall, "t5_total_count");
    k = 0;
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].emit) begin
        if (k < b_cap.size())
          check($sformatf("t5_vec%0d", i), 64'(b_cap[k]), 64'(tbl[i].exp));
        k++;
      end
    end
    check("t5_rd_while_empty", 64'(b_viol), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
